// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Shares one Wishbone-style master bus between two requesters
//   (0 = host command path, 1 = capture/DMA path). Arbitration is
//   round-robin, one transaction at a time. An ack watchdog aborts a
//   cycle after TIMEOUT bus cycles without ack_i. Completion and timeout
//   are reported per requester.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   reqN_i/weN_i/adrN_i/datN_i   requester N request (level) and command
//   doneN_o/errN_o/rdatN_o   requester N completion pulse, timeout flag,
//                            read data (valid with doneN_o)
//   gnt_o                    one-hot current bus owner, 00 when idle
//   cyc_o/stb_o/we_o/adr_o/dat_o  master bus outputs
//   ack_i/dat_i              slave acknowledge and read data
module wb_bus_arbiter #(
   parameter int unsigned ADR_W   = 8,
   parameter int unsigned DAT_W   = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_i,
   input  logic             we0_i,
   input  logic [ADR_W-1:0] adr0_i,
   input  logic [DAT_W-1:0] dat0_i,
   output logic             done0_o,
   output logic             err0_o,
   output logic [DAT_W-1:0] rdat0_o,
   input  logic             req1_i,
   input  logic             we1_i,
   input  logic [ADR_W-1:0] adr1_i,
   input  logic [DAT_W-1:0] dat1_i,
   output logic             done1_o,
   output logic             err1_o,
   output logic [DAT_W-1:0] rdat1_o,
   output logic [1:0]       gnt_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [ADR_W-1:0] adr_o,
   output logic [DAT_W-1:0] dat_o,
   input  logic             ack_i,
   input  logic [DAT_W-1:0] dat_i
);

   typedef enum logic {
      IDLE,
      BUS
   } state_t;

   // Counter value in the last permitted bus cycle without ack.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             win;

   logic             cyc_d, stb_d, we_d;
   logic [ADR_W-1:0] adr_d;
   logic [DAT_W-1:0] dat_d;
   logic [1:0]       gnt_d;
   logic             done0_d, done1_d, err0_d, err1_d;
   logic [DAT_W-1:0] rdat0_d, rdat1_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         cyc_o   <= 1'b0;
         stb_o   <= 1'b0;
         we_o    <= 1'b0;
         adr_o   <= '0;
         dat_o   <= '0;
         gnt_o   <= '0;
         done0_o <= 1'b0;
         done1_o <= 1'b0;
         err0_o  <= 1'b0;
         err1_o  <= 1'b0;
         rdat0_o <= '0;
         rdat1_o <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         cyc_o   <= cyc_d;
         stb_o   <= stb_d;
         we_o    <= we_d;
         adr_o   <= adr_d;
         dat_o   <= dat_d;
         gnt_o   <= gnt_d;
         done0_o <= done0_d;
         done1_o <= done1_d;
         err0_o  <= err0_d;
         err1_o  <= err1_d;
         rdat0_o <= rdat0_d;
         rdat1_o <= rdat1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      win     = 1'b0;
      cyc_d   = cyc_o;
      stb_d   = stb_o;
      we_d    = we_o;
      adr_d   = adr_o;
      dat_d   = dat_o;
      gnt_d   = gnt_o;
      done0_d = 1'b0;
      done1_d = 1'b0;
      err0_d  = 1'b0;
      err1_d  = 1'b0;
      rdat0_d = rdat0_o;
      rdat1_d = rdat1_o;

      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               // Contention goes to whoever was not granted last;
               // a lone requester wins outright.
               win     = (req0_i && req1_i) ? ~last_q : req1_i;
               owner_d = win;
               last_d  = win;
               cnt_d   = '0;
               state_d = BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = win ? we1_i  : we0_i;
               adr_d   = win ? adr1_i : adr0_i;
               dat_d   = win ? dat1_i : dat0_i;
               gnt_d   = win ? 2'b10  : 2'b01;
            end
         end
         BUS: begin
            cnt_d = cnt_q + 8'd1;
            // ack takes priority over a coincident timeout.
            if (ack_i || (cnt_q == TO_LAST)) begin
               state_d = IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               gnt_d   = '0;
               cnt_d   = '0;
               if (owner_q) begin
                  done1_d = 1'b1;
                  err1_d  = ~ack_i;
                  if (!we_o) rdat1_d = ack_i ? dat_i : '0;
               end else begin
                  done0_d = 1'b1;
                  err0_d  = ~ack_i;
                  if (!we_o) rdat0_d = ack_i ? dat_i : '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
//   Directed scenarios with literal expectations, then randomized
//   requesters and slave, all checked every cycle against a
//   transaction-level model of the arbiter.
module tb_wb_bus_arbiter;

   localparam int unsigned TO = 4;

   logic       clk, rst;
   logic       req0, we0, req1, we1;
   logic [7:0] adr0, dat0, adr1, dat1;
   logic       done0, err0, done1, err1;
   logic [7:0] rdat0, rdat1;
   logic [1:0] gnt;
   logic       cyc, stb, we, ack;
   logic [7:0] adr, dat, dati;

   int errors = 0;
   int checks = 0;

   wb_bus_arbiter #(.ADR_W(8), .DAT_W(8), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .we0_i(we0), .adr0_i(adr0), .dat0_i(dat0),
      .done0_o(done0), .err0_o(err0), .rdat0_o(rdat0),
      .req1_i(req1), .we1_i(we1), .adr1_i(adr1), .dat1_i(dat1),
      .done1_o(done1), .err1_o(err1), .rdat1_o(rdat1),
      .gnt_o(gnt), .cyc_o(cyc), .stb_o(stb), .we_o(we),
      .adr_o(adr), .dat_o(dat), .ack_i(ack), .dat_i(dati)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // ---------------- transaction-level reference model ----------------
   int         m_owner = -1;    // -1 idle, else requester index
   int         m_last  = 1;     // requester granted most recently
   int         m_seen  = 0;     // strobe cycles already completed
   bit         m_we;
   bit [7:0]   m_adr, m_dat;
   bit [1:0]   m_done, m_err;
   bit [7:0]   m_rdat [2];
   bit         m_valid = 0;

   always @(posedge clk) begin
      bit r0, r1;
      r0 = req0; r1 = req1;
      m_done = '0; m_err = '0;
      if (rst) begin
         m_owner = -1; m_last = 1; m_seen = 0;
         m_we = 0; m_adr = 0; m_dat = 0;
         m_rdat[0] = 0; m_rdat[1] = 0;
      end else if (m_owner < 0) begin
         if (r0 || r1) begin
            m_owner = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
            m_last  = m_owner;
            m_seen  = 0;
            m_we    = m_owner ? we1  : we0;
            m_adr   = m_owner ? adr1 : adr0;
            m_dat   = m_owner ? dat1 : dat0;
         end
      end else begin
         m_seen = m_seen + 1;
         if (ack || m_seen == TO) begin
            m_done[m_owner] = 1'b1;
            m_err[m_owner]  = !ack;
            if (!m_we) m_rdat[m_owner] = ack ? dati : 8'h00;
            m_owner = -1;
         end
      end
      m_valid = 1;
      #1;
      if (m_valid) begin
         chk("gnt",   32'(gnt),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
         chk("cyc",   32'(cyc),   32'(m_owner >= 0));
         chk("stb",   32'(stb),   32'(m_owner >= 0));
         chk("we",    32'(we),    32'(m_we));
         chk("adr",   32'(adr),   32'(m_adr));
         chk("dat",   32'(dat),   32'(m_dat));
         chk("done0", 32'(done0), 32'(m_done[0]));
         chk("done1", 32'(done1), 32'(m_done[1]));
         chk("err0",  32'(err0),  32'(m_err[0]));
         chk("err1",  32'(err1),  32'(m_err[1]));
         chk("rdat0", 32'(rdat0), 32'(m_rdat[0]));
         chk("rdat1", 32'(rdat1), 32'(m_rdat[1]));
      end
   end

   // ---------------- stimulus ----------------
   bit pend [2];

   initial begin
      int n;
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      adr0 = 0; adr1 = 0; dat0 = 0; dat1 = 0; ack = 0; dati = 0;
      step(); step();
      chk("rst stb", 32'(stb), 32'd0);
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst rdat0", 32'(rdat0), 32'd0);
      rst = 0;
      step();

      // single read, ack in the second strobe cycle
      req0 = 1; we0 = 0; adr0 = 8'h12;
      step();
      chk("rd stb", 32'(stb), 32'd1);
      chk("rd adr", 32'(adr), 32'h12);
      chk("rd gnt", 32'(gnt), 32'h1);
      step();
      chk("rd stb2", 32'(stb), 32'd1);
      ack = 1; dati = 8'hA5; req0 = 0;
      step();
      ack = 0;
      chk("rd done0", 32'(done0), 32'd1);
      chk("rd rdat0", 32'(rdat0), 32'hA5);
      chk("rd err0", 32'(err0), 32'd0);
      chk("rd stb off", 32'(stb), 32'd0);
      step();
      chk("rd done0 1cyc", 32'(done0), 32'd0);

      // single write, immediate ack, read data must not be captured
      req1 = 1; we1 = 1; adr1 = 8'h40; dat1 = 8'h3C;
      step();
      chk("wr we", 32'(we), 32'd1);
      chk("wr dat", 32'(dat), 32'h3C);
      chk("wr gnt", 32'(gnt), 32'h2);
      ack = 1; dati = 8'hFF; req1 = 0;
      step();
      ack = 0;
      chk("wr done1", 32'(done1), 32'd1);
      chk("wr rdat1", 32'(rdat1), 32'h00);
      chk("wr stb off", 32'(stb), 32'd0);
      step();

      // contention: both held high, ack every strobe
      req0 = 1; we0 = 1; req1 = 1; we1 = 1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("rr stb", 32'(stb), 32'(i % 2));
         if (stb) begin
            chk("rr gnt", 32'(gnt), (((i - 1) / 2) % 2 == 0) ? 32'h1 : 32'h2);
            ack = 1;
         end else begin
            ack = 0;
         end
      end
      req0 = 0; req1 = 0; ack = 0;
      step();

      // timeout: read with no ack
      req0 = 1; we0 = 0; adr0 = 8'h55;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         req0 = 0;
         if (done0) break;
         if (stb) n++;
      end
      chk("to stb cycles", 32'(n), 32'd4);
      chk("to done0", 32'(done0), 32'd1);
      chk("to err0", 32'(err0), 32'd1);
      chk("to rdat0", 32'(rdat0), 32'h00);
      req1 = 1; we1 = 0; adr1 = 8'h21;
      step();
      ack = 1; dati = 8'h77; req1 = 0;
      step();
      ack = 0;
      chk("post-to done1", 32'(done1), 32'd1);
      chk("post-to err1", 32'(err1), 32'd0);
      chk("post-to rdat1", 32'(rdat1), 32'h77);
      step();

      // asynchronous reset in the middle of a bus cycle
      req0 = 1; we0 = 1; adr0 = 8'h9A; dat0 = 8'h5E;
      step();
      chk("mid stb", 32'(stb), 32'd1);
      #2 rst = 1;
      #1;
      chk("async stb", 32'(stb), 32'd0);
      chk("async cyc", 32'(cyc), 32'd0);
      chk("async gnt", 32'(gnt), 32'd0);
      step();
      chk("rst no done0", 32'(done0), 32'd0);
      rst = 0; req0 = 0;
      step();
      req0 = 1; req1 = 1; we0 = 0; we1 = 0;
      step();
      chk("post-rst gnt", 32'(gnt), 32'h1);
      ack = 1; req0 = 0;
      step();
      ack = 0;
      step();
      chk("post-rst gnt1", 32'(gnt), 32'h2);
      ack = 1; req1 = 0;
      step();
      ack = 0;
      step();

      // spurious ack while idle, then ack coincident with timeout
      ack = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("spur done", 32'({done1, done0}), 32'd0);
         chk("spur stb", 32'(stb), 32'd0);
      end
      ack = 0;
      req0 = 1; we0 = 0; adr0 = 8'h33;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         req0 = 0;
         if (done0) break;
         if (stb) n++;
         if (n == 4) begin ack = 1; dati = 8'h99; end
      end
      ack = 0;
      chk("coinc done0", 32'(done0), 32'd1);
      chk("coinc err0", 32'(err0), 32'd0);
      chk("coinc rdat0", 32'(rdat0), 32'h99);
      step();

      // randomized requesters and slave
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            bit dn, g, rq, w;
            logic [7:0] a, d;
            dn = k ? done1 : done0;
            g  = gnt[k];
            rq = k ? req1 : req0;
            w  = k ? we1 : we0;
            a  = k ? adr1 : adr0;
            d  = k ? dat1 : dat0;
            if (!pend[k] || dn) begin
               if (($urandom % 3) == 0) begin
                  pend[k] = 1; rq = 1;
                  w = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
               end else begin
                  pend[k] = 0; rq = 0;
               end
            end else if (g && ($urandom % 4) == 0) begin
               rq = 0;
            end
            if (k == 1) begin req1 = rq; we1 = w; adr1 = a; dat1 = d; end
            else        begin req0 = rq; we0 = w; adr0 = a; dat0 = d; end
         end
         ack  = stb ? (($urandom % 4) == 0) : (($urandom % 8) == 0);
         dati = 8'($urandom);
      end
      req0 = 0; req1 = 0; ack = 0;
      repeat (8) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single 8-bit Wishbone-style master bus (stb_o/we_o/adr_o/dat_o in, ack_i/dat_i back) between two requesters: host command path (0) and capture/DMA path (1).
- Round-robin arbitration, one transaction at a time, per-requester completion/error reporting.
- Ack-timeout watchdog so a dead slave cannot hang the bus.
- Its bus outputs feed the slaves and the existing read monitor directly.

Parameters:
- ADR_W, 8, address width
- DAT_W, 8, data width
- TIMEOUT, 255, max bus cycles waiting for ack_i before abort (legal range 1..255)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- req0_i  in  1  requester 0 transaction request (level)
- we0_i  in  1  requester 0 write enable (1=write, 0=read)
- adr0_i  in  ADR_W  requester 0 address
- dat0_i  in  DAT_W  requester 0 write data
- done0_o  out  1  requester 0 completion pulse, 1 cycle
- err0_o  out  1  requester 0 timeout flag, valid with done0_o
- rdat0_o  out  DAT_W  requester 0 read data, valid with done0_o
- req1_i, we1_i, adr1_i, dat1_i, done1_o, err1_o, rdat1_o  (same as requester 0)
- gnt_o  out  2  one-hot current bus owner; 00 when idle
- cyc_o  out  1  bus cycle active
- stb_o  out  1  bus strobe
- we_o  out  1  bus write enable
- adr_o  out  ADR_W  bus address
- dat_o  out  DAT_W  bus write data
- ack_i  in  1  slave acknowledge
- dat_i  in  DAT_W  slave read data

Behaviour:
- Reset (async, immediate): cyc_o=stb_o=we_o=0, adr_o=dat_o=0, gnt_o=00, done*/err*=0, rdat*=0, state IDLE, timeout counter 0, last-grant pointer=1 (requester 0 wins first).
- State IDLE:
  - On a clock edge with any req*_i high, select the winner, latch its we/adr/dat into we_o/adr_o/dat_o, set cyc_o=stb_o=1 and the gnt_o bit, then go to BUS.
  - Both requesting: the requester not in the last-grant pointer wins. The pointer updates to the winner.
  - Only one requesting: it wins regardless of the pointer.
- State BUS: timeout counter increments each cycle from 0.
  - ack_i=1: latch dat_i into the owner's rdat (reads only; writes leave rdat unchanged). Pulse the owner's done=1 with err=0 for one cycle. Clear cyc_o/stb_o/gnt_o on the same edge. Go to IDLE.
  - No ack, counter==TIMEOUT-1: abort. Clear cyc_o/stb_o/gnt_o. Pulse the owner's done=1 and err=1; rdat=0 for reads. Go to IDLE.
  - ack_i and timeout in the same cycle: ack wins (normal completion).
- Latency:
  - req sampled at edge N -> stb_o high after edge N.
  - ack_i high at edge M -> done high for cycle M..M+1, stb_o low after edge M.
  - Minimum cycles: 1 stb cycle plus 1 mandatory IDLE cycle between transactions (stb_o never held high across two transactions).
- Requester contract:
  - Hold req/we/adr/dat stable until done; values are latched at grant, so later changes are ignored.
  - req still high in the cycle after done is a new request.
  - Dropping req mid-transaction does not cancel it; done still pulses.
- ack_i while IDLE is ignored; no done, no state change.
- we_o/adr_o/dat_o hold their last values in IDLE; only stb_o/cyc_o qualify them.
- done0_o and done1_o never pulse in the same cycle.
- Reset mid-BUS: transaction dropped silently, no done/err emitted, stb_o low asynchronously.

Test Plan:
- Single read: req0, we0=0, adr0=0x12; slave acks 2 cycles after stb with dat_i=0xA5 -> stb_o high 2 cycles, adr_o=0x12, done0_o 1 cycle, rdat0_o=0xA5, err0_o=0, gnt_o=01 during BUS.
- Single write: req1, we1=1, adr1=0x40, dat1=0x3C; immediate ack -> we_o=1, dat_o=0x3C, stb_o high 1 cycle, done1_o pulse, rdat1_o unchanged.
- Contention: req0 and req1 held high continuously, ack after 1 cycle -> grants alternate 0,1,0,1, first grant to 0, one IDLE cycle between each stb_o.
- Timeout: TIMEOUT=4, req0 read, no ack -> stb_o high exactly 4 cycles, then done0_o=1, err0_o=1, rdat0_o=0x00; next request is served normally.
- Reset mid-op: assert rst_i asynchronously while stb_o=1 -> stb_o/cyc_o/gnt_o drop without waiting for a clock edge, no done pulse; after release, req1 and req0 together -> requester 0 granted.
- Spurious ack: ack_i pulsed in IDLE with no requests -> no done, stb_o stays 0; then ack_i and timeout coincident -> done with err=0.
